// File: rtl/img_stream_host.sv
// Collects one frame of pixels from a byte stream, hands it to the accelerator, and returns its digit.
// Latency: acc_start 1 cycle after the last pixel beat; r_valid 1 cycle after the acc_done rising edge.
// Backpressure: s_ready is low outside RECV; the result is held in RESP until r_ready.
module img_stream_host #(
  parameter int IMG_SIZE = 784,
  parameter int TIMEOUT  = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [IMG_SIZE*8-1:0] img_data,
  output logic                  acc_start,
  input  logic                  acc_done,
  input  logic [3:0]            acc_digit,
  output logic [3:0]            r_digit,
  output logic                  r_err,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [9:0]            px_cnt,
  output logic                  busy
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RECV  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [9:0]            px_cnt_q, px_cnt_d;
  logic [IMG_SIZE*8-1:0] img_q, img_d;
  logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                  done_prev_q, done_prev_d;
  logic [3:0]            r_digit_q, r_digit_d;
  logic                  r_err_q, r_err_d;

  logic beat;
  logic last_beat;
  logic done_edge;
  logic timed_out;

  assign beat      = s_valid && (state_q == S_RECV);
  assign last_beat = beat && (px_cnt_q == 10'(IMG_SIZE - 1));
  // A done that was already high in the previous cycle (e.g. held from the last frame) is not a new result.
  assign done_edge = acc_done && !done_prev_q;
  assign timed_out = (wait_cnt_q == WW'(TIMEOUT - 1));

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RECV;
      px_cnt_q    <= '0;
      img_q       <= '0;
      wait_cnt_q  <= '0;
      done_prev_q <= 1'b0;
      r_digit_q   <= '0;
      r_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_cnt_q    <= px_cnt_d;
      img_q       <= img_d;
      wait_cnt_q  <= wait_cnt_d;
      done_prev_q <= done_prev_d;
      r_digit_q   <= r_digit_d;
      r_err_q     <= r_err_d;
    end
  end

  // Next-state: done edge takes priority over timeout when both land in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RECV:  if (last_beat) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (done_edge || timed_out) state_d = S_RESP;
      S_RESP:  if (r_ready) state_d = S_RECV;
      default: state_d = S_RECV;
    endcase
  end

  // Datapath updates: pixel capture, wait counting, result latching.
  always_comb begin
    px_cnt_d    = px_cnt_q;
    img_d       = img_q;
    wait_cnt_d  = wait_cnt_q;
    done_prev_d = acc_done;
    r_digit_d   = r_digit_q;
    r_err_d     = r_err_q;
    case (state_q)
      S_RECV: begin
        if (beat) begin
          img_d[{px_cnt_q, 3'b000} +: 8] = s_data;
          px_cnt_d = px_cnt_q + 10'd1;
        end
      end
      S_START: wait_cnt_d = '0;
      S_WAIT: begin
        if (done_edge) begin
          r_digit_d = acc_digit;
          r_err_d   = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (timed_out) begin
            r_digit_d = 4'hF;
            r_err_d   = 1'b1;
          end
        end
      end
      S_RESP: begin
        // Frame buffer is left as-is; the next frame overwrites it slot by slot.
        if (r_ready) px_cnt_d = '0;
      end
      default: ;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    s_ready   = (state_q == S_RECV);
    acc_start = (state_q == S_START);
    r_valid   = (state_q == S_RESP);
    busy      = (state_q != S_RECV);
    px_cnt    = px_cnt_q;
    img_data  = img_q;
    r_digit   = r_digit_q;
    r_err     = r_err_q;
  end

endmodule

// File: tb/tb_img_stream_host.sv
module tb_img_stream_host;

  logic          clk;
  logic          rst;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic [6271:0] img_data;
  logic          acc_start;
  logic          acc_done;
  logic [3:0]    acc_digit;
  logic [3:0]    r_digit;
  logic          r_err;
  logic          r_valid;
  logic          r_ready;
  logic [9:0]    px_cnt;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  img_stream_host #(.IMG_SIZE(784), .TIMEOUT(4095)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .img_data  (img_data),
    .acc_start (acc_start),
    .acc_done  (acc_done),
    .acc_digit (acc_digit),
    .r_digit   (r_digit),
    .r_err     (r_err),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .px_cnt    (px_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] img_b(input int k);
    return img_data[k*8 +: 8];
  endfunction

  // Streams a full frame with s_valid held high; ends on the cycle after the last beat.
  task automatic send_full(input logic [7:0] x);
    int miss;
    miss = 0;
    for (int k = 0; k < 784; k++) begin
      s_valid = 1'b1;
      s_data  = 8'(k) ^ x;
      if (!s_ready) miss++;
      tick;
    end
    s_valid = 1'b0;
    chk("frame s_ready held", 32'(miss), 32'd0);
    chk("frame acc_start", 32'(acc_start), 32'd1);
    chk("frame px_cnt full", 32'(px_cnt), 32'd784);
  endtask

  typedef struct {
    logic       rst;
    logic       sv;
    logic [7:0] sd;
    logic       ad;
    logic       exp_rdy;
    logic       exp_busy;
    logic       exp_start;
    logic [9:0] exp_px;
    logic [7:0] exp_b0;
    logic [7:0] exp_b1;
  } vec_t;

  vec_t vt[7];

  int   beats, starts, pxbad, cyc, cnt, extra, unstable;

  initial begin
    rst = 1'b1; s_data = '0; s_valid = 1'b0; acc_done = 1'b0; acc_digit = '0; r_ready = 1'b0;

    //        rst   sv    sd     ad    rdy   busy  start px      b0     b1
    vt[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 8'h00, 8'h00};
    vt[1] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 10'd1, 8'hA5, 8'h00};
    vt[2] = '{1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 10'd1, 8'hA5, 8'h00};
    vt[3] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 10'd2, 8'hA5, 8'h3C};
    vt[4] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 10'd3, 8'hA5, 8'h3C};
    vt[5] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 8'h00, 8'h00};
    vt[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 8'h00, 8'h00};

    for (int i = 0; i < 7; i++) begin
      rst = vt[i].rst; s_valid = vt[i].sv; s_data = vt[i].sd; acc_done = vt[i].ad;
      tick;
      chk($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(vt[i].exp_rdy));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].exp_busy));
      chk($sformatf("vec%0d acc_start", i), 32'(acc_start), 32'(vt[i].exp_start));
      chk($sformatf("vec%0d r_valid", i), 32'(r_valid), 32'd0);
      chk($sformatf("vec%0d px_cnt", i), 32'(px_cnt), 32'(vt[i].exp_px));
      chk($sformatf("vec%0d img0", i), 32'(img_b(0)), 32'(vt[i].exp_b0));
      chk($sformatf("vec%0d img1", i), 32'(img_b(1)), 32'(vt[i].exp_b1));
    end
    rst = 1'b0; s_valid = 1'b0; acc_done = 1'b0;

    // Frame A: byte k = k mod 256, accelerator answers 6 after 1200 cycles.
    send_full(8'h00);
    chk("A s_ready after last", 32'(s_ready), 32'd0);
    chk("A img400", 32'(img_b(400)), 32'h90);
    chk("A img783", 32'(img_b(783)), 32'h0F);
    s_valid = 1'b1;
    extra = 0;
    for (int i = 0; i < 1200; i++) begin
      tick;
      if (acc_start || r_valid || s_ready) extra++;
    end
    chk("A quiet during wait", 32'(extra), 32'd0);
    acc_done = 1'b1; acc_digit = 4'd6;
    tick;
    chk("A r_valid", 32'(r_valid), 32'd1);
    chk("A r_digit", 32'(r_digit), 32'd6);
    chk("A r_err", 32'(r_err), 32'd0);
    chk("A img held", 32'(img_b(400)), 32'h90);
    s_valid = 1'b0; acc_digit = 4'd2;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (!r_valid || r_digit != 4'd6 || r_err) unstable++;
    end
    chk("A result stable", 32'(unstable), 32'd0);
    r_ready = 1'b1;
    tick;
    r_ready = 1'b0;
    chk("A r_valid drop", 32'(r_valid), 32'd0);
    chk("A back to recv", 32'(s_ready), 32'd1);
    chk("A px_cnt cleared", 32'(px_cnt), 32'd0);
    chk("A busy low", 32'(busy), 32'd0);

    // Frame B: random gaps, acc_done left high from frame A so WAIT must time out.
    beats = 0; starts = 0; pxbad = 0; cyc = 0;
    while (beats < 784 && cyc < 6000) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'(beats * 7 + 3);
      if (s_valid && s_ready) beats++;
      tick;
      cyc++;
      if (px_cnt != 10'(beats)) pxbad++;
      if (acc_start) starts++;
    end
    chk("B beats", 32'(beats), 32'd784);
    chk("B px_cnt tracks beats", 32'(pxbad), 32'd0);
    chk("B acc_start after last", 32'(acc_start), 32'd1);
    s_valid = 1'b1;
    cnt = 0;
    while (!r_valid && cnt < 5000) begin
      tick;
      cnt++;
      if (acc_start) starts++;
    end
    s_valid = 1'b0;
    chk("B timeout cycles", 32'(cnt), 32'd4096);
    chk("B single start", 32'(starts), 32'd1);
    chk("B r_digit timeout", 32'(r_digit), 32'hF);
    chk("B r_err", 32'(r_err), 32'd1);
    chk("B px_cnt stays", 32'(px_cnt), 32'd784);
    chk("B img0", 32'(img_b(0)), 32'h03);
    chk("B img1", 32'(img_b(1)), 32'h0A);
    chk("B img783", 32'(img_b(783)), 32'h6C);
    r_ready = 1'b1;
    tick;
    r_ready = 1'b0;
    chk("B back to recv", 32'(s_ready), 32'd1);

    // Frame C: reset after 300 beats, then a full frame aborted mid-WAIT by reset.
    acc_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      s_valid = 1'b1; s_data = 8'hFF;
      tick;
    end
    s_valid = 1'b0;
    chk("C px_cnt 300", 32'(px_cnt), 32'd300);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("C px_cnt reset", 32'(px_cnt), 32'd0);
    chk("C img0 reset", 32'(img_b(0)), 32'd0);
    chk("C img299 reset", 32'(img_b(299)), 32'd0);
    chk("C s_ready after rst", 32'(s_ready), 32'd1);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (acc_start || r_valid) extra++;
    end
    chk("C no start after abort", 32'(extra), 32'd0);
    send_full(8'h33);
    chk("C img5", 32'(img_b(5)), 32'h36);
    for (int i = 0; i < 4; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      acc_done = (i >= 5 && i < 10);
      acc_digit = 4'd4;
      tick;
      if (acc_start || r_valid || busy || px_cnt != 10'd0) extra++;
    end
    acc_done = 1'b0;
    chk("C wait abort quiet", 32'(extra), 32'd0);

    // Frame D: done edge lands on the very cycle the timeout would fire.
    send_full(8'hC3);
    for (int i = 0; i < 4095; i++) tick;
    chk("D no result yet", 32'(r_valid), 32'd0);
    acc_done = 1'b1; acc_digit = 4'd9;
    tick;
    chk("D r_valid", 32'(r_valid), 32'd1);
    chk("D done wins digit", 32'(r_digit), 32'd9);
    chk("D done wins err", 32'(r_err), 32'd0);
    r_ready = 1'b1;
    tick;
    r_ready = 1'b0;
    chk("D back to recv", 32'(s_ready), 32'd1);
    chk("D px_cnt cleared", 32'(px_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
